branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameters SHALL be: DEPTH, default 4, in-flight prediction records (power of 2, >=2); FLUSH_CYCLES, default 2, flush pulse length (>=1).
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 pred_valid_i / pred_ready_o  input/output  1/1  fetch record handshake; transfer when both high.
REQ-005 pred_pc_i, pred_target_i  input  32 each  fetched control-instruction PC and predicted target.
REQ-006 pred_taken_i  input  1  predicted taken.
REQ-007 res_valid_i / res_ready_o  input/output  1/1  execute resolution handshake; transfer when both high.
REQ-008 res_pc_i, res_target_i  input  32 each  resolved PC and actual target.
REQ-009 res_kind_i  input  2  00 branch, 01 jal, 10 jalr, 11 reserved.
REQ-010 res_taken_i  input  1  actual branch outcome (ignored for jal/jalr, treated as 1).
REQ-011 upd_is_branch_o, upd_is_jal_o, upd_is_jalr_o  output  1 each  predictor update strobes (one-hot or all 0).
REQ-012 upd_pc_o, upd_target_o  output  32 each  update index PC and target; upd_taken_o  output  1  outcome.
REQ-013 flush_o  output  1  pipeline flush; redirect_pc_o  output  32  fetch restart PC; mispredict_o  output  1  one-cycle pulse.
REQ-014 err_o  output  1  sticky protocol error.

Function
REQ-015 Records SHALL be held in a DEPTH-entry in-order FIFO {pc, taken, target}; resolutions SHALL consume the head in program order.
REQ-016 pred_ready_o SHALL equal (state==RUN) && !full, from registered count; a push while full is impossible, a same-cycle pop does not enable a push.
REQ-017 res_ready_o SHALL equal (state==RUN).
REQ-018 A push in the same cycle as a resolve SHALL NOT be visible to that resolve (no bypass).
REQ-019 Resolve with FIFO empty SHALL use prediction {taken=0}, set err_o, and pop nothing.
REQ-020 Resolve with head.pc != res_pc_i SHALL set err_o, pop the head, and force mispredict.
REQ-021 Mispredict SHALL be: predicted taken != actual taken, or both taken and head.target != res_target_i.
REQ-022 Kind 11 SHALL pop the head with no update strobe and no mispredict check.
REQ-023 For kinds 00/01/10, upd_* SHALL pulse for exactly one cycle, the cycle after the handshake: upd_pc_o=res_pc_i, upd_target_o=res_target_i, upd_taken_o=actual taken; correct predictions are also reported.
REQ-024 Redirect PC SHALL be res_target_i if actual taken, else res_pc_i+4 (32-bit wrap, 0xFFFFFFFC -> 0x00000000).
REQ-025 FSM states SHALL be RUN and FLUSH; RUN->FLUSH on a mispredicting resolve; FLUSH->RUN after FLUSH_CYCLES cycles via a down-counter.
REQ-026 On RUN->FLUSH, in the cycle after the handshake: mispredict_o pulses once, flush_o is high for FLUSH_CYCLES cycles, redirect_pc_o is loaded and held until the next mispredict, and the FIFO is emptied.
REQ-027 A push accepted in the same cycle as a mispredicting resolve SHALL be discarded by the flush.
REQ-028 err_o SHALL clear only on reset.

Reset
REQ-029 While rst_n=0 at a clock edge: FIFO empty, state RUN, flush counter 0; all upd_*, flush_o, mispredict_o, err_o 0; redirect_pc_o 0x00000000.
REQ-030 Reset asserted during FLUSH SHALL abort the flush immediately; the first cycle after release is RUN with pred_ready_o=1.

Configuration
REQ-031 With macro BRANCH_RESOLVE_STATS_EN defined, outputs stat_resolved_o[31:0] and stat_mispredict_o[31:0] SHALL exist: they count kind 00/01/10 resolves and mispredicts, wrap at 2^32, and reset to 0.
REQ-032 Without BRANCH_RESOLVE_STATS_EN, the ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-033 Push {0x100,taken=1,0x200}; resolve branch pc 0x100 taken target 0x200 -> next cycle upd_is_branch_o=1, upd_taken_o=1, flush_o=0.
REQ-034 Push {0x100,taken=0}; resolve taken target 0x180 -> mispredict_o 1 cycle, flush_o 2 cycles, redirect_pc_o=0x180, FIFO empty, res_ready_o=0 during flush.
REQ-035 Push {0x104,taken=1,0x300}; resolve not taken -> redirect_pc_o=0x108; jal pc 0x40 with target mismatch -> redirect to res_target_i.
REQ-036 Push 4 records with no resolves -> pred_ready_o=0; push+resolve in the same cycle while full -> push refused, count 3 next cycle.
REQ-037 Resolve with FIFO empty -> err_o=1 sticky; PC-mismatch resolve -> mispredict plus err_o; reset mid-FLUSH -> flush_o=0 the next cycle.
REQ-038 With BRANCH_RESOLVE_STATS_EN: 3 resolves including 1 mispredict -> stat_resolved_o=3, stat_mispredict_o=1; kind 11 does not count.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Matches execute-stage branch resolutions against the fetch-time predictions
// held in an in-order FIFO. It emits one-cycle predictor update strobes, and
// on a mispredict it raises a timed pipeline flush with a fetch redirect PC.
// Optional feature macro: BRANCH_RESOLVE_STATS_EN adds resolve/mispredict counters.
module branch_resolve_unit #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pred_valid_i,
  output logic        pred_ready_o,
  input  logic [31:0] pred_pc_i,
  input  logic [31:0] pred_target_i,
  input  logic        pred_taken_i,
  input  logic        res_valid_i,
  output logic        res_ready_o,
  input  logic [31:0] res_pc_i,
  input  logic [31:0] res_target_i,
  input  logic [1:0]  res_kind_i,
  input  logic        res_taken_i,
  output logic        upd_is_branch_o,
  output logic        upd_is_jal_o,
  output logic        upd_is_jalr_o,
  output logic [31:0] upd_pc_o,
  output logic [31:0] upd_target_o,
  output logic        upd_taken_o,
  output logic        flush_o,
  output logic [31:0] redirect_pc_o,
  output logic        mispredict_o,
  output logic        err_o
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  output logic [31:0] stat_resolved_o,
  output logic [31:0] stat_mispredict_o
`endif
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int FCW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [FCW-1:0] FLUSH_C = FCW'(FLUSH_CYCLES);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t         state;
  logic [FCW-1:0] flush_cnt;

  logic [31:0] mem_pc     [DEPTH];
  logic [31:0] mem_target [DEPTH];
  logic        mem_taken  [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic        push_fire;
  logic        res_fire;
  logic        fifo_empty;
  logic        pop;
  logic        is_update;
  logic        actual_taken;
  logic        pred_taken_eff;
  logic        pc_mismatch;
  logic        target_mismatch;
  logic        mispredict_now;
  logic [31:0] redirect_next;

  // Handshakes are gated by the registered state and occupancy only.
  assign pred_ready_o = (state == RUN) && (count != DEPTH_C);
  assign res_ready_o  = (state == RUN);
  assign push_fire    = pred_valid_i && pred_ready_o;
  assign res_fire     = res_valid_i && res_ready_o;
  assign fifo_empty   = (count == '0);
  assign pop          = res_fire && !fifo_empty;

  // Compare the resolution against the FIFO head; an empty FIFO predicts not-taken.
  always_comb begin
    is_update       = (res_kind_i != 2'b11);
    actual_taken    = (res_kind_i == 2'b00) ? res_taken_i : 1'b1;
    pred_taken_eff  = fifo_empty ? 1'b0 : mem_taken[rd_ptr];
    pc_mismatch     = !fifo_empty && (mem_pc[rd_ptr] != res_pc_i);
    target_mismatch = pred_taken_eff && actual_taken && (mem_target[rd_ptr] != res_target_i);
    mispredict_now  = res_fire && is_update &&
                      (pc_mismatch || (pred_taken_eff != actual_taken) || target_mismatch);
    redirect_next   = actual_taken ? res_target_i : (res_pc_i + 32'd4);
  end

  // Prediction record storage; contents need no reset since count guards reads.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem_pc[wr_ptr]     <= pred_pc_i;
      mem_target[wr_ptr] <= pred_target_i;
      mem_taken[wr_ptr]  <= pred_taken_i;
    end
  end

  // FIFO pointers and occupancy; a mispredict empties it, dropping any same-cycle push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (mispredict_now) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + PW'(1);
      if (pop)       rd_ptr <= rd_ptr + PW'(1);
      case ({push_fire, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // RUN/FLUSH controller with the flush pulse, mispredict pulse and redirect PC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= RUN;
      flush_cnt     <= '0;
      flush_o       <= 1'b0;
      mispredict_o  <= 1'b0;
      redirect_pc_o <= 32'h0000_0000;
    end else begin
      mispredict_o <= 1'b0;
      case (state)
        RUN: begin
          if (mispredict_now) begin
            state         <= FLUSH;
            flush_cnt     <= FLUSH_C;
            flush_o       <= 1'b1;
            mispredict_o  <= 1'b1;
            redirect_pc_o <= redirect_next;
          end
        end
        FLUSH: begin
          if (flush_cnt == FCW'(1)) begin
            state     <= RUN;
            flush_cnt <= '0;
            flush_o   <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - FCW'(1);
          end
        end
        default: begin
          state   <= RUN;
          flush_o <= 1'b0;
        end
      endcase
    end
  end

  // One-cycle predictor update strobes for branch, jal and jalr resolutions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upd_is_branch_o <= 1'b0;
      upd_is_jal_o    <= 1'b0;
      upd_is_jalr_o   <= 1'b0;
      upd_pc_o        <= 32'h0;
      upd_target_o    <= 32'h0;
      upd_taken_o     <= 1'b0;
    end else begin
      upd_is_branch_o <= res_fire && (res_kind_i == 2'b00);
      upd_is_jal_o    <= res_fire && (res_kind_i == 2'b01);
      upd_is_jalr_o   <= res_fire && (res_kind_i == 2'b10);
      if (res_fire && is_update) begin
        upd_pc_o     <= res_pc_i;
        upd_target_o <= res_target_i;
        upd_taken_o  <= actual_taken;
      end else begin
        upd_taken_o  <= 1'b0;
      end
    end
  end

  // Sticky protocol error: resolve on an empty FIFO or against the wrong head PC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_o <= 1'b0;
    end else if (res_fire && (fifo_empty || pc_mismatch)) begin
      err_o <= 1'b1;
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  // Free-running statistics on predictor-relevant resolves and mispredicts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_resolved_o   <= 32'h0;
      stat_mispredict_o <= 32'h0;
    end else begin
      if (res_fire && is_update) stat_resolved_o   <= stat_resolved_o + 32'd1;
      if (mispredict_now)        stat_mispredict_o <= stat_mispredict_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit
// Self-checking bench: a reference FIFO of predictions produces expected
// update records, pushed to a scoreboard at resolve time and compared by a
// monitor when the DUT strobes an update. Scenario tasks check flush/redirect/err.
module tb_branch_resolve_unit;

  localparam int DEPTH        = 4;
  localparam int FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pred_valid_i = 1'b0;
  logic        pred_ready_o;
  logic [31:0] pred_pc_i = '0;
  logic [31:0] pred_target_i = '0;
  logic        pred_taken_i = 1'b0;
  logic        res_valid_i = 1'b0;
  logic        res_ready_o;
  logic [31:0] res_pc_i = '0;
  logic [31:0] res_target_i = '0;
  logic [1:0]  res_kind_i = '0;
  logic        res_taken_i = 1'b0;
  logic        upd_is_branch_o;
  logic        upd_is_jal_o;
  logic        upd_is_jalr_o;
  logic [31:0] upd_pc_o;
  logic [31:0] upd_target_o;
  logic        upd_taken_o;
  logic        flush_o;
  logic [31:0] redirect_pc_o;
  logic        mispredict_o;
  logic        err_o;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] stat_resolved_o;
  logic [31:0] stat_mispredict_o;
`endif

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } pred_t;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic        mis;
  } upd_t;

  pred_t mq[$];
  upd_t  sb[$];
  upd_t  mon_e;
  int    checks = 0;
  int    errors = 0;
  logic  exp_err = 1'b0;
  int unsigned exp_res_cnt = 0;
  int unsigned exp_mis_cnt = 0;

  branch_resolve_unit #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pred_valid_i    (pred_valid_i),
    .pred_ready_o    (pred_ready_o),
    .pred_pc_i       (pred_pc_i),
    .pred_target_i   (pred_target_i),
    .pred_taken_i    (pred_taken_i),
    .res_valid_i     (res_valid_i),
    .res_ready_o     (res_ready_o),
    .res_pc_i        (res_pc_i),
    .res_target_i    (res_target_i),
    .res_kind_i      (res_kind_i),
    .res_taken_i     (res_taken_i),
    .upd_is_branch_o (upd_is_branch_o),
    .upd_is_jal_o    (upd_is_jal_o),
    .upd_is_jalr_o   (upd_is_jalr_o),
    .upd_pc_o        (upd_pc_o),
    .upd_target_o    (upd_target_o),
    .upd_taken_o     (upd_taken_o),
    .flush_o         (flush_o),
    .redirect_pc_o   (redirect_pc_o),
    .mispredict_o    (mispredict_o),
    .err_o           (err_o)
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    .stat_resolved_o   (stat_resolved_o),
    .stat_mispredict_o (stat_mispredict_o)
`endif
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Scoreboard monitor: every update strobe must match the oldest expected record.
  always @(negedge clk) begin
    if (upd_is_branch_o || upd_is_jal_o || upd_is_jalr_o) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL upd_unexpected got pc=%h kind_bits=%b expected no update",
                 upd_pc_o, {upd_is_jalr_o, upd_is_jal_o, upd_is_branch_o});
      end else begin
        mon_e = sb.pop_front();
        if ({upd_is_jalr_o, upd_is_jal_o, upd_is_branch_o} !==
              {mon_e.kind == 2'b10, mon_e.kind == 2'b01, mon_e.kind == 2'b00} ||
            upd_pc_o !== mon_e.pc || upd_target_o !== mon_e.target ||
            upd_taken_o !== mon_e.taken || mispredict_o !== mon_e.mis) begin
          errors++;
          $display("[TB] FAIL upd_record got kind_bits=%b pc=%h tgt=%h taken=%b mis=%b expected kind=%0d pc=%h tgt=%h taken=%b mis=%b",
                   {upd_is_jalr_o, upd_is_jal_o, upd_is_branch_o}, upd_pc_o, upd_target_o,
                   upd_taken_o, mispredict_o, mon_e.kind, mon_e.pc, mon_e.target,
                   mon_e.taken, mon_e.mis);
        end
      end
    end else if (mispredict_o) begin
      checks++;
      errors++;
      $display("[TB] FAIL mispredict_no_update got mispredict_o=1 expected 0");
    end
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    mq.delete();
    sb.delete();
    exp_err     = 1'b0;
    exp_res_cnt = 0;
    exp_mis_cnt = 0;
  endtask

  // One cycle of stimulus: optional push and/or resolve, with the reference model updated.
  task automatic drive(input logic p_en, input logic [31:0] p_pc, input logic p_taken,
                       input logic [31:0] p_tgt, input logic p_acc,
                       input logic r_en, input logic [1:0] r_kind, input logic [31:0] r_pc,
                       input logic r_taken, input logic [31:0] r_tgt, output logic mis);
    pred_t       h;
    upd_t        u;
    logic        act;
    logic        pt;
    logic        pcok;
    logic [31:0] ptg;
    mis = 1'b0;
    if (r_en) begin
      act = (r_kind == 2'b00) ? r_taken : 1'b1;
      if (mq.size() == 0) begin
        pt = 1'b0; ptg = 32'h0; pcok = 1'b1; exp_err = 1'b1;
      end else begin
        h = mq.pop_front();
        pt = h.taken; ptg = h.target; pcok = (h.pc == r_pc);
        if (!pcok) exp_err = 1'b1;
      end
      if (r_kind != 2'b11) begin
        mis = !pcok || (pt != act) || (pt && act && (ptg != r_tgt));
        u.kind = r_kind; u.pc = r_pc; u.target = r_tgt; u.taken = act; u.mis = mis;
        sb.push_back(u);
        exp_res_cnt++;
        if (mis) begin
          exp_mis_cnt++;
          mq.delete();
        end
      end
    end
    if (p_en && p_acc && !mis) begin
      h.pc = p_pc; h.taken = p_taken; h.target = p_tgt;
      mq.push_back(h);
    end
    pred_valid_i  = p_en;
    pred_pc_i     = p_pc;
    pred_taken_i  = p_taken;
    pred_target_i = p_tgt;
    res_valid_i   = r_en;
    res_kind_i    = r_kind;
    res_pc_i      = r_pc;
    res_taken_i   = r_taken;
    res_target_i  = r_tgt;
    step(1);
    pred_valid_i = 1'b0;
    res_valid_i  = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    logic m;
    drive(1'b1, pc, taken, tgt, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0, m);
  endtask

  task automatic resolve(input logic [1:0] kind, input logic [31:0] pc, input logic taken,
                         input logic [31:0] tgt, output logic mis);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, kind, pc, taken, tgt, mis);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pred_valid_i = 1'b0;
    res_valid_i  = 1'b0;
    step(2);
    clear_model();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pred_valid_i = 1'b1;
    res_valid_i  = 1'b1;
    step(2);
    pred_valid_i = 1'b0;
    res_valid_i  = 1'b0;
    checks++;
    if ({flush_o, mispredict_o, err_o} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_flags got flush=%b mis=%b err=%b expected 000",
               flush_o, mispredict_o, err_o);
    end
    checks++;
    if ({upd_is_branch_o, upd_is_jal_o, upd_is_jalr_o, upd_taken_o} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_upd got %b expected 0000",
               {upd_is_branch_o, upd_is_jal_o, upd_is_jalr_o, upd_taken_o});
    end
    checks++;
    if (redirect_pc_o !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_redirect got %h expected 00000000", redirect_pc_o);
    end
    checks++;
    if (pred_ready_o !== 1'b1 || res_ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready got pred=%b res=%b expected 1 1", pred_ready_o, res_ready_o);
    end
    clear_model();
    rst_n = 1'b1;
  endtask

  task automatic test_correct_predict();
    logic m;
    push(32'h100, 1'b1, 32'h200);
    resolve(2'b00, 32'h100, 1'b1, 32'h200, m);
    checks++;
    if (upd_is_branch_o !== 1'b1 || upd_taken_o !== 1'b1 || flush_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL correct_predict got br=%b taken=%b flush=%b expected 1 1 0",
               upd_is_branch_o, upd_taken_o, flush_o);
    end
    step(1);
    checks++;
    if (upd_is_branch_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL upd_one_cycle got %b expected 0", upd_is_branch_o);
    end
  endtask

  task automatic test_mispredict();
    logic m;
    push(32'h100, 1'b0, 32'h0);
    drive(1'b1, 32'h999, 1'b0, 32'h0, 1'b1, 1'b1, 2'b00, 32'h100, 1'b1, 32'h180, m);
    checks++;
    if (mispredict_o !== 1'b1 || flush_o !== 1'b1 || redirect_pc_o !== 32'h180) begin
      errors++;
      $display("[TB] FAIL mis_first got mis=%b flush=%b redir=%h expected 1 1 00000180",
               mispredict_o, flush_o, redirect_pc_o);
    end
    checks++;
    if (res_ready_o !== 1'b0 || pred_ready_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mis_ready got res=%b pred=%b expected 0 0", res_ready_o, pred_ready_o);
    end
    step(1);
    checks++;
    if (mispredict_o !== 1'b0 || flush_o !== 1'b1 || res_ready_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mis_second got mis=%b flush=%b res_ready=%b expected 0 1 0",
               mispredict_o, flush_o, res_ready_o);
    end
    step(1);
    checks++;
    if (flush_o !== 1'b0 || res_ready_o !== 1'b1 || redirect_pc_o !== 32'h180) begin
      errors++;
      $display("[TB] FAIL mis_end got flush=%b res_ready=%b redir=%h expected 0 1 00000180",
               flush_o, res_ready_o, redirect_pc_o);
    end
    push(32'h700, 1'b0, 32'h0);
    resolve(2'b00, 32'h700, 1'b0, 32'h0, m);
    checks++;
    if (err_o !== exp_err || flush_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_emptied got err=%b flush=%b expected %b 0", err_o, flush_o, exp_err);
    end
  endtask

  task automatic test_redirect();
    logic m;
    push(32'h104, 1'b1, 32'h300);
    resolve(2'b00, 32'h104, 1'b0, 32'h300, m);
    checks++;
    if (redirect_pc_o !== 32'h108 || flush_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL redirect_not_taken got %h flush=%b expected 00000108 1", redirect_pc_o, flush_o);
    end
    step(FLUSH_CYCLES);
    push(32'h40, 1'b1, 32'h80);
    resolve(2'b01, 32'h40, 1'b0, 32'h90, m);
    checks++;
    if (redirect_pc_o !== 32'h90 || mispredict_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL redirect_jal got %h mis=%b expected 00000090 1", redirect_pc_o, mispredict_o);
    end
    step(FLUSH_CYCLES);
    push(32'hFFFF_FFFC, 1'b1, 32'h10);
    resolve(2'b00, 32'hFFFF_FFFC, 1'b0, 32'h10, m);
    checks++;
    if (redirect_pc_o !== 32'h0) begin
      errors++;
      $display("[TB] FAIL redirect_wrap got %h expected 00000000", redirect_pc_o);
    end
    step(FLUSH_CYCLES);
    push(32'h60, 1'b1, 32'h70);
    resolve(2'b10, 32'h60, 1'b0, 32'h70, m);
    checks++;
    if (flush_o !== 1'b0 || upd_taken_o !== 1'b1 || redirect_pc_o !== 32'h0) begin
      errors++;
      $display("[TB] FAIL jalr_correct got flush=%b taken=%b redir=%h expected 0 1 00000000",
               flush_o, upd_taken_o, redirect_pc_o);
    end
    push(32'h20, 1'b0, 32'h0);
    push(32'h24, 1'b0, 32'h0);
    resolve(2'b11, 32'h20, 1'b1, 32'h5, m);
    checks++;
    if ({upd_is_branch_o, upd_is_jal_o, upd_is_jalr_o, mispredict_o, flush_o} !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL kind11_silent got %b expected 00000",
               {upd_is_branch_o, upd_is_jal_o, upd_is_jalr_o, mispredict_o, flush_o});
    end
    resolve(2'b00, 32'h24, 1'b0, 32'h0, m);
    checks++;
    if (flush_o !== 1'b0 || err_o !== exp_err) begin
      errors++;
      $display("[TB] FAIL kind11_pop got flush=%b err=%b expected 0 %b", flush_o, err_o, exp_err);
    end
  endtask

  task automatic test_full();
    logic m;
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(32'h1000 + 32'(4 * i), 1'b0, 32'h0);
    checks++;
    if (pred_ready_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_ready got %b expected 0", pred_ready_o);
    end
    drive(1'b1, 32'h2000, 1'b0, 32'h0, 1'b0, 1'b1, 2'b00, 32'h1000, 1'b0, 32'h0, m);
    checks++;
    if (pred_ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_pop_ready got %b expected 1", pred_ready_o);
    end
    push(32'h1010, 1'b0, 32'h0);
    checks++;
    if (pred_ready_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL count_three got ready=%b expected 0 after one push", pred_ready_o);
    end
    for (int i = 1; i <= DEPTH; i++) resolve(2'b00, 32'h1000 + 32'(4 * i), 1'b0, 32'h0, m);
    checks++;
    if (err_o !== 1'b0 || pred_ready_o !== 1'b1 || flush_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL back_to_back_drain got err=%b ready=%b flush=%b expected 0 1 0",
               err_o, pred_ready_o, flush_o);
    end
  endtask

  task automatic test_errors();
    logic m;
    do_reset();
    resolve(2'b00, 32'h50, 1'b0, 32'h0, m);
    checks++;
    if (err_o !== 1'b1 || flush_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL empty_resolve got err=%b flush=%b expected 1 0", err_o, flush_o);
    end
    step(3);
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL err_sticky got %b expected 1", err_o);
    end
    do_reset();
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_reset got %b expected 0", err_o);
    end
    push(32'h500, 1'b0, 32'h0);
    resolve(2'b00, 32'h504, 1'b0, 32'h0, m);
    checks++;
    if (mispredict_o !== 1'b1 || err_o !== 1'b1 || flush_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pc_mismatch got mis=%b err=%b flush=%b expected 1 1 1",
               mispredict_o, err_o, flush_o);
    end
    rst_n = 1'b0;
    step(1);
    checks++;
    if (flush_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_flush got flush=%b expected 0", flush_o);
    end
    clear_model();
    rst_n = 1'b1;
    step(1);
    checks++;
    if (pred_ready_o !== 1'b1 || res_ready_o !== 1'b1 || flush_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL after_release got pred=%b res=%b flush=%b expected 1 1 0",
               pred_ready_o, res_ready_o, flush_o);
    end
  endtask

  task automatic test_back_to_back();
    logic        m;
    logic        pt;
    logic        act;
    logic [31:0] pc;
    logic [31:0] tg;
    logic [31:0] rtg;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      pc  = 32'h3000 + 32'(8 * i);
      pt  = 1'($urandom_range(0, 1));
      tg  = {$urandom_range(0, 32'h3FFF), 2'b00};
      act = 1'($urandom_range(0, 1));
      rtg = ($urandom_range(0, 1) == 0) ? tg : tg + 32'h40;
      push(pc, pt, tg);
      resolve(2'b00, pc, act, rtg, m);
      checks++;
      if (flush_o !== m) begin
        errors++;
        $display("[TB] FAIL rand_flush iter %0d got %b expected %b", i, flush_o, m);
      end
      if (m) begin
        checks++;
        if (redirect_pc_o !== (act ? rtg : pc + 32'd4)) begin
          errors++;
          $display("[TB] FAIL rand_redirect iter %0d got %h expected %h",
                   i, redirect_pc_o, act ? rtg : pc + 32'd4);
        end
        step(FLUSH_CYCLES);
      end
    end
  endtask

`ifdef BRANCH_RESOLVE_STATS_EN
  task automatic test_stats();
    logic m;
    do_reset();
    push(32'h10, 1'b1, 32'h20);
    resolve(2'b00, 32'h10, 1'b1, 32'h20, m);
    push(32'h14, 1'b1, 32'h24);
    resolve(2'b11, 32'h14, 1'b1, 32'h24, m);
    push(32'h18, 1'b0, 32'h0);
    resolve(2'b01, 32'h18, 1'b0, 32'h30, m);
    step(FLUSH_CYCLES);
    push(32'h1C, 1'b0, 32'h0);
    resolve(2'b00, 32'h1C, 1'b0, 32'h0, m);
    checks++;
    if (stat_resolved_o !== 32'd3 || stat_mispredict_o !== 32'd1) begin
      errors++;
      $display("[TB] FAIL stats got resolved=%0d mis=%0d expected 3 1",
               stat_resolved_o, stat_mispredict_o);
    end
  endtask
`endif

  initial begin
    $display("[TB] branch_resolve_unit bench start");
    test_reset();
    test_correct_predict();
    test_mispredict();
    test_redirect();
    test_full();
    test_back_to_back();
    test_errors();
`ifdef BRANCH_RESOLVE_STATS_EN
    test_stats();
`endif
    step(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
